// File: rtl/alu8_share_arbiter_pkg.sv
// alu8_arb_pkg: shared constants, opcodes and FSM states for alu8_share_arbiter.
// TIMEOUT is only consumed when ALU_ARB_TIMEOUT_EN is defined.
package alu8_arb_pkg;

    localparam int W       = 8;
    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 15;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/alu8_share_arbiter_if.sv
// alu8_share_arbiter_if: request/response bundle between requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface alu8_share_arbiter_if;
    import alu8_arb_pkg::*;

    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*W-1:0] req_a;
    logic [N_REQ*W-1:0] req_b;
    logic [N_REQ*2-1:0] req_op;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   rsp_valid;
    logic [W-1:0]       rsp_data;
    logic               rsp_cout;
    logic [N_REQ-1:0]   rsp_ready;
    logic               rsp_drop;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_cout, rsp_drop
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_cout, rsp_drop
    );

endinterface

// File: rtl/alu8_share_arbiter_rr_pick4.sv
// rr_pick4: combinational round-robin picker over 4 requests.
// Returns the first set request at or after ptr (mod 4).
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] gnt_idx,
    output logic       any
);

    logic [1:0] idx;

    // Walk from farthest to nearest so the nearest set request wins.
    always_comb begin
        gnt_idx = ptr;
        idx     = '0;
        any     = |req;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/alu8_share_arbiter.sv
// alu8_share_arbiter: round-robin share of one external 8-bit ALU among 4 requesters.
// Define ALU_ARB_TIMEOUT_EN to drop results not accepted within TIMEOUT cycles.
module alu8_share_arbiter
    import alu8_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    alu8_share_arbiter_if.slave bus,
    output logic [W-1:0]        alu_a,
    output logic [W-1:0]        alu_b,
    output logic [1:0]          alu_op,
    input  logic [W-1:0]        alu_res,
    input  logic                alu_cout
);

    state_t     st, st_n;
    logic [1:0] ptr, owner, gnt;
    logic       any, take, acc, tmo;
    logic [W-1:0] rsp_data_q;
    logic         rsp_cout_q;

    rr_pick4 u_pick (
        .req     (bus.req_valid),
        .ptr     (ptr),
        .gnt_idx (gnt),
        .any     (any)
    );

    assign take = (st == ST_IDLE) && any && !rst;
    assign acc  = (st == ST_RESP) && bus.rsp_ready[owner];

    assign bus.req_ready = take ? onehot4(gnt) : '0;
    assign bus.rsp_valid = (st == ST_RESP) ? onehot4(owner) : '0;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_cout  = rsp_cout_q;

    always_comb begin
        st_n = st;
        unique case (st)
            ST_IDLE: if (take) st_n = ST_EXEC;
            ST_EXEC: st_n = ST_RESP;
            ST_RESP: if (acc || tmo) st_n = ST_IDLE;
            default: st_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= ST_IDLE;
            ptr        <= '0;
            owner      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_data_q <= '0;
            rsp_cout_q <= 1'b0;
        end else begin
            st <= st_n;
            if (take) begin
                owner  <= gnt;
                alu_a  <= bus.req_a[int'(gnt)*W +: W];
                alu_b  <= bus.req_b[int'(gnt)*W +: W];
                alu_op <= bus.req_op[int'(gnt)*2 +: 2];
            end
            // Carry is only meaningful for ADD; logic ops report 0.
            if (st == ST_EXEC) begin
                rsp_data_q <= alu_res;
                rsp_cout_q <= (alu_op == OP_ADD) && alu_cout;
            end
            if (acc || tmo) begin
                ptr <= owner + 2'd1;
            end
        end
    end

`ifdef ALU_ARB_TIMEOUT_EN
    logic [3:0] cnt;
    logic       drop_q;

    // An accept in the final cycle wins over the timeout.
    assign tmo = (st == ST_RESP) && !bus.rsp_ready[owner]
               && (cnt == 4'(TIMEOUT - 1));
    assign bus.rsp_drop = drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= tmo;
            if (st == ST_EXEC) begin
                cnt <= '0;
            end else if ((st == ST_RESP) && !bus.rsp_ready[owner]) begin
                cnt <= cnt + 4'd1;
            end
        end
    end
`else
    assign tmo          = 1'b0;
    assign bus.rsp_drop = 1'b0;
`endif

endmodule

// File: tb/tb_alu8_share_arbiter.sv
// tb_alu8_share_arbiter: directed stimulus, transaction-level model compared every cycle.
// Honours ALU_ARB_TIMEOUT_EN for the timeout scenario.
module tb_alu8_share_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] alu_a, alu_b, alu_res;
    logic [1:0] alu_op;
    logic       alu_cout;

    alu8_share_arbiter_if bus ();

    alu8_share_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_res  (alu_res),
        .alu_cout (alu_cout)
    );

    always #5 clk = ~clk;

    // External ALU; its adder carry is always live so masking is exercised.
    always_comb begin
        logic [8:0] s;
        s        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_cout = s[8];
        case (alu_op)
            2'b00:   alu_res = s[7:0];
            2'b01:   alu_res = alu_a & alu_b;
            2'b10:   alu_res = alu_a | alu_b;
            default: alu_res = alu_a ^ alu_b;
        endcase
    end

`ifdef ALU_ARB_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif
    localparam int TMO = 15;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: transaction view (idle / computing / holding result) with queue of grants.
    bit m_on = 1'b0;
    int m_age, m_owner, m_ptr, m_wait, m_drop;
    int m_a, m_b, m_op, m_res, m_c, m_pres, m_pc;
    int gq[$];

    function automatic void calc(input int a, input int b, input int op,
                                 output int r, output int c);
        c = 0;
        case (op)
            0: begin r = (a + b) % 256; c = (a + b) / 256; end
            1: r = a & b;
            2: r = a | b;
            default: r = a ^ b;
        endcase
    endfunction

    always @(negedge clk) begin
        int  w;
        bit  anyv;
        int  e_rr, e_rv;
        w = 0;
        anyv = 1'b0;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
            if (!anyv && bus.req_valid[i]) begin
                anyv = 1'b1;
                w = i;
            end
        end
        if (m_on) begin
            e_rr = (!rst && m_age == 0 && anyv) ? (1 << w) : 0;
            e_rv = (m_age == 2) ? (1 << m_owner) : 0;
            chk("req_ready", 32'(bus.req_ready), e_rr);
            chk("rsp_valid", 32'(bus.rsp_valid), e_rv);
            chk("rsp_data", 32'(bus.rsp_data), m_res);
            chk("rsp_cout", 32'(bus.rsp_cout), m_c);
            chk("rsp_drop", 32'(bus.rsp_drop), m_drop);
            chk("alu_a", 32'(alu_a), m_a);
            chk("alu_b", 32'(alu_b), m_b);
            chk("alu_op", 32'(alu_op), m_op);
            for (int i = 0; i < 4; i++) begin
                if (bus.req_ready[i]) gq.push_back(i);
            end
        end
        m_drop = 0;
        if (rst) begin
            m_on = 1'b1;
            m_age = 0; m_ptr = 0; m_owner = 0; m_wait = 0;
            m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_c = 0;
        end else if (m_on) begin
            case (m_age)
                0: if (anyv) begin
                    m_owner = w;
                    m_a = int'(bus.req_a[8*w +: 8]);
                    m_b = int'(bus.req_b[8*w +: 8]);
                    m_op = int'(bus.req_op[2*w +: 2]);
                    calc(m_a, m_b, m_op, m_pres, m_pc);
                    m_age = 1;
                end
                1: begin
                    m_res = m_pres;
                    m_c = m_pc;
                    m_wait = 0;
                    m_age = 2;
                end
                default: begin
                    if (bus.rsp_ready[m_owner]) begin
                        m_age = 0;
                        m_ptr = (m_owner + 1) % 4;
                    end else begin
                        m_wait++;
                        if (TMO_ON && m_wait == TMO) begin
                            m_drop = 1;
                            m_age = 0;
                            m_ptr = (m_owner + 1) % 4;
                        end
                    end
                end
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] op);
        bus.req_a[8*i +: 8] = a;
        bus.req_b[8*i +: 8] = b;
        bus.req_op[2*i +: 2] = op;
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic wait_valid(input int i, input int lim, input string nm);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.rsp_valid[i] && t < lim);
        chk(nm, 32'(bus.rsp_valid[i]), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base, cnt;
        bit seen;
        int exp_g[5];
        exp_g = '{0, 1, 2, 3, 0};
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_op = '0;
        bus.rsp_ready = '0;

        // 1: reset, idle
        do_reset();
        @(negedge clk);
        chk("t1_req_ready", 32'(bus.req_ready), 0);
        chk("t1_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("t1_rsp_data", 32'(bus.rsp_data), 0);
        chk("t1_alu_a", 32'(alu_a), 0);
        step();

        // 2: single ADD with carry
        set_req(0, 8'hF0, 8'h20, 2'b00);
        @(negedge clk);
        chk("t2_req_ready", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = '0;
        @(negedge clk);
        chk("t2_exec_valid", 32'(bus.rsp_valid), 0);
        @(negedge clk);
        chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("t2_rsp_data", 32'(bus.rsp_data), 32'h10);
        chk("t2_rsp_cout", 32'(bus.rsp_cout), 1);
        @(negedge clk);
        step();
        bus.rsp_ready = 4'b0001;
        @(negedge clk);
        chk("t2_accept_valid", 32'(bus.rsp_valid), 32'h1);
        step();
        bus.rsp_ready = '0;
        @(negedge clk);
        chk("t2_cleared", 32'(bus.rsp_valid), 0);

        // 3: all requesting XOR, round-robin order
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_req(i, 8'(8'h11 * (i + 1)), 8'(8'h0F << i), 2'b11);
        end
        bus.rsp_ready = 4'b1111;
        base = gq.size();
        repeat (15) @(negedge clk);
        chk("t3_grant_count", 32'(gq.size() - base), 5);
        if (gq.size() - base >= 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("t3_grant_order", 32'(gq[base + k]), 32'(exp_g[k]));
            end
        end
        step();
        bus.req_valid = '0;

        // 4: non-owner accepts ignored; next search starts after owner
        do_reset();
        set_req(2, 8'h80, 8'h80, 2'b00);
        @(negedge clk);
        chk("t4_req_ready", 32'(bus.req_ready), 32'h4);
        step();
        bus.req_valid = '0;
        bus.rsp_ready = 4'b1011;
        wait_valid(2, 5, "t4_rsp_valid");
        chk("t4_rsp_data", 32'(bus.rsp_data), 0);
        chk("t4_rsp_cout", 32'(bus.rsp_cout), 1);
        repeat (4) @(negedge clk);
        chk("t4_hold", 32'(bus.rsp_valid), 32'h4);
        step();
        for (int i = 0; i < 4; i++) begin
            set_req(i, 8'(i + 1), 8'h02, 2'b00);
        end
        @(negedge clk);
        chk("t4_no_grant_resp", 32'(bus.req_ready), 0);
        step();
        bus.rsp_ready = 4'b0100;
        @(negedge clk);
        chk("t4_accept_valid", 32'(bus.rsp_valid), 32'h4);
        chk("t4_no_bypass", 32'(bus.req_ready), 0);
        step();
        bus.rsp_ready = '0;
        @(negedge clk);
        chk("t4_next_grant", 32'(bus.req_ready), 32'h8);
        step();
        bus.req_valid = '0;

        // 5: reset during EXEC abandons the op
        do_reset();
        set_req(1, 8'hCC, 8'hAA, 2'b01);
        @(negedge clk);
        chk("t5_req_ready", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_exec_valid", 32'(bus.rsp_valid), 0);
        step();
        @(negedge clk);
        chk("t5_rst_valid", 32'(bus.rsp_valid), 0);
        chk("t5_rst_data", 32'(bus.rsp_data), 0);
        step();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_no_rsp", 32'(bus.rsp_valid), 0);
        step();
        set_req(1, 8'hCC, 8'hAA, 2'b01);
        bus.rsp_ready = 4'b0010;
        @(negedge clk);
        chk("t5_regrant", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_valid = '0;
        wait_valid(1, 5, "t5_rsp_valid");
        chk("t5_rsp_data", 32'(bus.rsp_data), 32'h88);
        chk("t5_rsp_cout", 32'(bus.rsp_cout), 0);
        step();
        bus.rsp_ready = '0;

        // 6: unaccepted result
        do_reset();
        set_req(3, 8'h0F, 8'h30, 2'b10);
        @(negedge clk);
        chk("t6_req_ready", 32'(bus.req_ready), 32'h8);
        step();
        bus.req_valid = '0;
        wait_valid(3, 5, "t6_rsp_valid");
        chk("t6_rsp_data", 32'(bus.rsp_data), 32'h3F);
`ifdef ALU_ARB_TIMEOUT_EN
        cnt = 1;
        seen = 1'b0;
        for (int t = 0; t < 30 && !seen; t++) begin
            @(negedge clk);
            if (bus.rsp_drop) begin
                seen = 1'b1;
                chk("t6_drop_valid", 32'(bus.rsp_valid), 0);
            end else if (bus.rsp_valid[3]) begin
                cnt++;
            end
        end
        chk("t6_drop_seen", 32'(seen), 1);
        chk("t6_valid_cycles", 32'(cnt), 15);
        @(negedge clk);
        chk("t6_drop_pulse", 32'(bus.rsp_drop), 0);
`else
        cnt = 0;
        seen = 1'b0;
        repeat (100) @(negedge clk);
        chk("t6_still_valid", 32'(bus.rsp_valid), 32'h8);
        chk("t6_no_drop", 32'(bus.rsp_drop), 0);
        step();
        bus.rsp_ready = 4'b1000;
        step();
        bus.rsp_ready = '0;
        @(negedge clk);
        chk("t6_accepted", 32'(bus.rsp_valid), 0);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
